// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg : state encodings and widths shared by the elevator FSM/timer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int STATE_W            = 3;
  localparam int CNT_W              = 3;
  localparam int TRAVEL_SEC_DEFAULT = 5;

  typedef enum logic [STATE_W-1:0] {
    STATE_IDLE       = 3'd0,
    STATE_FLOOR1     = 3'd1,
    STATE_FLOOR2     = 3'd2,
    STATE_GOING_TO_1 = 3'd3,
    STATE_GOING_TO_2 = 3'd4
  } state_e;

  // Codes 5..7 are not legal FSM states and never count as travelling.
  function automatic logic is_going(input logic [STATE_W-1:0] s);
    return (s == STATE_GOING_TO_1) || (s == STATE_GOING_TO_2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_travel_timer_tick_prescaler.sv
// ============================================================================
// tick_prescaler : modulo-CLK_HZ cycle counter, pulses tick on terminal count
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] C_TERM = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] count_q;
  logic [PRE_W-1:0] count_d;

  // clr with en loads 1 so the clearing cycle is itself the first counted cycle.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clr) begin
      count_d = en ? PRE_W'(1) : '0;
    end else if (en) begin
      if (count_q == C_TERM) begin
        count_d = '0;
        tick    = 1'b1;
      end else begin
        count_d = count_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/elevator_travel_timer.sv
// ============================================================================
// elevator_travel_timer : whole-second travel countdown for the elevator FSM
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module elevator_travel_timer
  import elevator_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRAVEL_SEC = TRAVEL_SEC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   counting_value,
  output logic               sec_tick,
  output logic               arrive_pulse,
  output logic               moving
);

  if ((TRAVEL_SEC < 1) || (TRAVEL_SEC > 7)) begin : g_bad_travel_sec
    $error("elevator_travel_timer: TRAVEL_SEC must be in 1..7");
  end
  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("elevator_travel_timer: CLK_HZ must be at least 2");
  end

  localparam logic [CNT_W-1:0] C_TRAVEL = CNT_W'(TRAVEL_SEC);

  logic [CNT_W-1:0]   count_q, count_d;
  logic [STATE_W-1:0] prev_state_q;
  logic               sec_tick_q, sec_tick_d;
  logic               arrive_q, arrive_d;
  logic               moving_q;

  logic going;
  logic fresh_trip;
  logic pre_clr;
  logic pre_tick;

  assign going      = is_going(state);
  assign fresh_trip = going && (state != prev_state_q);
  assign pre_clr    = !going || fresh_trip;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (going),
    .tick (pre_tick)
  );

  // Reloading on every non-going cycle keeps the FSM from seeing 0 on entry.
  always_comb begin
    count_d    = count_q;
    sec_tick_d = 1'b0;
    arrive_d   = 1'b0;
    if (pre_clr) begin
      count_d = C_TRAVEL;
    end else if (pre_tick && (count_q != '0)) begin
      count_d    = count_q - CNT_W'(1);
      sec_tick_d = 1'b1;
      arrive_d   = (count_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= C_TRAVEL;
      prev_state_q <= STATE_IDLE;
      sec_tick_q   <= 1'b0;
      arrive_q     <= 1'b0;
      moving_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      prev_state_q <= state;
      sec_tick_q   <= sec_tick_d;
      arrive_q     <= arrive_d;
      moving_q     <= going;
    end
  end

  assign counting_value = count_q;
  assign sec_tick       = sec_tick_q;
  assign arrive_pulse   = arrive_q;
  assign moving         = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_travel_timer.sv
// ============================================================================
// tb_elevator_travel_timer : directed vectors and trip sequences for the timer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_elevator_travel_timer;

  localparam int CLK_HZ     = 10;
  localparam int TRAVEL_SEC = 5;
  localparam int TRIP       = CLK_HZ * TRAVEL_SEC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'd0;
  logic [2:0] counting_value;
  logic       sec_tick;
  logic       arrive_pulse;
  logic       moving;

  int checks   = 0;
  int failures = 0;

  elevator_travel_timer #(
    .CLK_HZ     (CLK_HZ),
    .TRAVEL_SEC (TRAVEL_SEC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .state          (state),
    .counting_value (counting_value),
    .sec_tick       (sec_tick),
    .arrive_pulse   (arrive_pulse),
    .moving         (moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] state;
    int         cv;
    int         tk;
    int         ar;
    int         mv;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int cv, input int tk, input int ar, input int mv);
    check({tag, "_cv"},     int'(counting_value), cv);
    check({tag, "_tick"},   int'(sec_tick),       tk);
    check({tag, "_arrive"}, int'(arrive_pulse),   ar);
    check({tag, "_moving"}, int'(moving),         mv);
  endtask

  // Drives a going state s as a fresh trip for n edges; k counts edges from entry.
  task automatic run_trip(input logic [2:0] s, input int n, input string tag);
    int cv, tk, ar;
    for (int k = 0; k < n; k++) begin
      state = s;
      step();
      cv = TRAVEL_SEC - (k + 1) / CLK_HZ;
      if (cv < 0) cv = 0;
      tk = (((k + 1) % CLK_HZ) == 0 && (k + 1) <= TRIP) ? 1 : 0;
      ar = ((k + 1) == TRIP) ? 1 : 0;
      expect_out($sformatf("%s_k%0d", tag, k), cv, tk, ar, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{1'b0, 3'd5, 5, 0, 0, 0};
    vecs[1] = '{1'b0, 3'd7, 5, 0, 0, 0};
    vecs[2] = '{1'b0, 3'd1, 5, 0, 0, 0};
    vecs[3] = '{1'b0, 3'd3, 5, 0, 0, 1};
    vecs[4] = '{1'b0, 3'd4, 5, 0, 0, 1};
    vecs[5] = '{1'b0, 3'd0, 5, 0, 0, 0};
    vecs[6] = '{1'b0, 3'd2, 5, 0, 0, 0};
    vecs[7] = '{1'b1, 3'd4, 5, 0, 0, 0};

    rst   = 1'b1;
    state = 3'd0;
    step();
    step();
    expect_out("reset", 5, 0, 0, 0);

    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      state = 3'd0;
      step();
      expect_out($sformatf("idle%0d", i), 5, 0, 0, 0);
    end

    for (int i = 0; i < 8; i++) begin
      rst   = vecs[i].rst;
      state = vecs[i].state;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].cv, vecs[i].tk, vecs[i].ar, vecs[i].mv);
    end
    rst = 1'b0;

    // Full trip up, hold at 0, then floor reload and a full trip down.
    state = 3'd0;
    step();
    run_trip(3'd4, TRIP + 6, "up");
    state = 3'd2;
    step();
    expect_out("floor2_reload", 5, 0, 0, 0);
    run_trip(3'd3, TRIP + 2, "down");

    // Reversal mid-trip restarts the whole countdown.
    state = 3'd0;
    step();
    run_trip(3'd4, 23, "prerev");
    check("prerev_cv3", int'(counting_value), 3);
    run_trip(3'd3, TRIP, "rev");

    // Reset mid-trip: no arrive, fresh trip afterwards.
    state = 3'd0;
    step();
    run_trip(3'd3, 30, "prerst");
    rst = 1'b1;
    step();
    expect_out("midrst", 5, 0, 0, 0);
    rst = 1'b0;
    run_trip(3'd3, TRIP, "postrst");

    // One-cycle floor gap clears the prescaler and reloads the count.
    state = 3'd0;
    step();
    run_trip(3'd3, 15, "pregap");
    state = 3'd1;
    step();
    expect_out("gap", 5, 0, 0, 0);
    run_trip(3'd3, TRIP, "postgap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
